// File: rtl/countdown_timer_ctrl.sv
// rtl/countdown_timer_ctrl.sv - sequencer for a two-digit decimal countdown counter chain
module countdown_timer_ctrl #(
    parameter int unsigned TICK_DIV   = 31_500_000,
    parameter logic [3:0]  START_TENS = 4'd6,
    parameter logic [3:0]  START_ONES = 4'd0
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       start,
    input  logic       pause,
    input  logic       restart,
    input  logic       tc_ones,
    input  logic       tc_tens,
    output logic       loadN,
    output logic       ena,
    output logic       ena_cnt_ones,
    output logic       ena_cnt_tens,
    output logic [3:0] datain_ones,
    output logic [3:0] datain_tens,
    output logic       running,
    output logic       expired,
    output logic       time_up
);

    localparam int unsigned   PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_EXPIRED
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          load_run_q, load_run_d;   // LOAD target: 1 = RUN, 0 = IDLE
    logic          time_up_d;
    logic          loadN_q, running_q, expired_q, time_up_q;
    logic          at_zero;

    // Both digits at 0: the chain has reached 00
    assign at_zero = tc_ones & tc_tens;

    // Next-state and prescaler logic; restart outranks start, which outranks pause
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        load_run_d = load_run_q;
        time_up_d  = 1'b0;
        if (restart) begin
            state_d    = S_LOAD;
            load_run_d = 1'b0;
        end else if (start) begin
            state_d    = S_LOAD;
            load_run_d = 1'b1;
        end else begin
            case (state_q)
                S_LOAD: begin
                    presc_d = '0;
                    state_d = load_run_q ? S_RUN : S_IDLE;
                end
                S_RUN: begin
                    if (at_zero) begin
                        // Stop before any further tick so the chain never wraps to 99
                        state_d   = S_EXPIRED;
                        time_up_d = 1'b1;
                    end else begin
                        // The pause cycle still counts, so resuming loses no prescaler time
                        presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
                        if (pause) begin
                            state_d = S_PAUSE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (pause) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State, prescaler and registered outputs
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q    <= S_IDLE;
            presc_q    <= '0;
            load_run_q <= 1'b0;
            loadN_q    <= 1'b1;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            time_up_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            load_run_q <= load_run_d;
            loadN_q    <= (state_d != S_LOAD);
            running_q  <= (state_d == S_RUN);
            expired_q  <= (state_d == S_EXPIRED);
            time_up_q  <= time_up_d;
        end
    end

    assign loadN        = loadN_q;
    assign running      = running_q;
    assign expired      = expired_q;
    assign time_up      = time_up_q;
    assign ena          = running_q & (presc_q == LAST) & ~at_zero;
    assign ena_cnt_ones = running_q;
    assign ena_cnt_tens = running_q & tc_ones;
    assign datain_ones  = START_ONES;
    assign datain_tens  = START_TENS;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// tb/tb_countdown_timer_ctrl.sv - directed self-checking bench for countdown_timer_ctrl
module tb_countdown_timer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetN, start, pause, restart;
    logic loadN, ena, ena_cnt_ones, ena_cnt_tens, running, expired, time_up;
    logic [3:0] datain_ones, datain_tens;
    logic [3:0] ones = 4'd0, tens = 4'd0;
    logic tc_ones, tc_tens;

    logic start_z, pause_z, restart_z;
    logic loadN_z, ena_z, ena_cnt_ones_z, ena_cnt_tens_z, running_z, expired_z, time_up_z;
    logic [3:0] datain_ones_z, datain_tens_z;
    logic [3:0] ones_z = 4'd5, tens_z = 4'd5;
    logic tc_ones_z, tc_tens_z;

    int n_ena = 0;
    int n_ena_z = 0;
    int checks = 0;
    int errors = 0;

    assign tc_ones   = (ones == 4'd0);
    assign tc_tens   = (tens == 4'd0);
    assign tc_ones_z = (ones_z == 4'd0);
    assign tc_tens_z = (tens_z == 4'd0);

    countdown_timer_ctrl #(.TICK_DIV(4), .START_TENS(4'd1), .START_ONES(4'd2)) u_dut (
        .clk(clk), .resetN(resetN), .start(start), .pause(pause), .restart(restart),
        .tc_ones(tc_ones), .tc_tens(tc_tens), .loadN(loadN), .ena(ena),
        .ena_cnt_ones(ena_cnt_ones), .ena_cnt_tens(ena_cnt_tens),
        .datain_ones(datain_ones), .datain_tens(datain_tens),
        .running(running), .expired(expired), .time_up(time_up)
    );

    countdown_timer_ctrl #(.TICK_DIV(4), .START_TENS(4'd0), .START_ONES(4'd0)) u_zero (
        .clk(clk), .resetN(resetN), .start(start_z), .pause(pause_z), .restart(restart_z),
        .tc_ones(tc_ones_z), .tc_tens(tc_tens_z), .loadN(loadN_z), .ena(ena_z),
        .ena_cnt_ones(ena_cnt_ones_z), .ena_cnt_tens(ena_cnt_tens_z),
        .datain_ones(datain_ones_z), .datain_tens(datain_tens_z),
        .running(running_z), .expired(expired_z), .time_up(time_up_z)
    );

    // Decimal down-counter chain models, plus tick pulse counters
    always @(posedge clk) begin
        if (!loadN) begin
            ones <= datain_ones;
            tens <= datain_tens;
        end else if (ena) begin
            if (ena_cnt_ones) ones <= (ones == 4'd0) ? 4'd9 : ones - 4'd1;
            if (ena_cnt_tens) tens <= (tens == 4'd0) ? 4'd9 : tens - 4'd1;
        end
        if (!loadN_z) begin
            ones_z <= datain_ones_z;
            tens_z <= datain_tens_z;
        end else if (ena_z) begin
            if (ena_cnt_ones_z) ones_z <= (ones_z == 4'd0) ? 4'd9 : ones_z - 4'd1;
            if (ena_cnt_tens_z) tens_z <= (tens_z == 4'd0) ? 4'd9 : tens_z - 4'd1;
        end
        if (ena)   n_ena   <= n_ena + 1;
        if (ena_z) n_ena_z <= n_ena_z + 1;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int digits();
        return int'(tens) * 10 + int'(ones);
    endfunction

    initial begin
        int ev;
        resetN = 1'b0; start = 1'b0; pause = 1'b0; restart = 1'b0;
        start_z = 1'b0; pause_z = 1'b0; restart_z = 1'b0;
        repeat (2) step();

        // Reset state
        chk("rst_loadN", loadN, 1);
        chk("rst_ena", ena, 0);
        chk("rst_running", running, 0);
        chk("rst_expired", expired, 0);
        chk("rst_time_up", time_up, 0);
        chk("rst_datain_tens", datain_tens, 1);
        chk("rst_datain_ones", datain_ones, 2);
        resetN = 1'b1;
        step();
        chk("idle_running", running, 0);

        // Test 1/2: full countdown 12 -> 00
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_load_loadN", loadN, 0);
        chk("t1_load_running", running, 0);
        chk("t1_load_datain", {datain_tens, datain_ones}, 8'h12);
        step();
        chk("t1_run_loadN", loadN, 1);
        for (int c = 1; c <= 48; c++) begin
            ev = 12 - (c - 1) / 4;
            chk("t1_digits", digits(), ev);
            chk("t1_running", running, 1);
            chk("t1_ena", ena, (c % 4 == 0));
            chk("t1_ena_cnt_tens", ena_cnt_tens, (ev % 10 == 0));
            step();
        end
        chk("t1_final_digits", digits(), 0);
        chk("t1_last_run_ena", ena, 0);
        chk("t1_last_run_time_up", time_up, 0);
        chk("t1_last_run_expired", expired, 0);
        step();
        chk("t1_exp_expired", expired, 1);
        chk("t1_exp_time_up", time_up, 1);
        chk("t1_exp_running", running, 0);
        step();
        chk("t1_time_up_pulse", time_up, 0);
        chk("t1_tick_total", n_ena, 12);

        // Test 4: EXPIRED holds, then start reloads
        for (int i = 0; i < 50; i++) begin
            chk("t4_hold_ena", ena, 0);
            chk("t4_hold_expired", expired, 1);
            step();
        end
        chk("t4_hold_ticks", n_ena, 12);
        chk("t4_hold_digits", digits(), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_load_loadN", loadN, 0);
        chk("t4_load_expired", expired, 0);
        step();
        chk("t4_run_running", running, 1);
        chk("t4_run_digits", digits(), 12);

        // Test 3: pause after two ticks, resume without lost or extra tick
        repeat (8) step();
        chk("t3_two_ticks_digits", digits(), 10);
        step();
        pause = 1'b1;
        step();
        pause = 1'b0;
        chk("t3_paused_running", running, 0);
        chk("t3_paused_ticks", n_ena, 14);
        for (int i = 0; i < 20; i++) begin
            chk("t3_paused_ena", ena, 0);
            step();
        end
        chk("t3_frozen_digits", digits(), 10);
        chk("t3_frozen_ticks", n_ena, 14);
        pause = 1'b1;
        step();
        pause = 1'b0;
        chk("t3_resume_running", running, 1);
        chk("t3_resume_ena", ena, 0);
        step();
        chk("t3_resume_tick", ena, 1);
        chk("t3_resume_cnt_tens", ena_cnt_tens, 1);
        step();
        chk("t3_after_digits", digits(), 9);
        chk("t3_after_ticks", n_ena, 15);

        // Test 5: restart+start together, pause in IDLE, pause+start, reset mid-run
        restart = 1'b1; start = 1'b1;
        step();
        restart = 1'b0; start = 1'b0;
        chk("t5_rs_loadN", loadN, 0);
        chk("t5_rs_running", running, 0);
        step();
        chk("t5_idle_running", running, 0);
        chk("t5_idle_loadN", loadN, 1);
        chk("t5_idle_digits", digits(), 12);
        pause = 1'b1;
        step();
        pause = 1'b0;
        chk("t5_idle_pause_ignored", running, 0);
        step();
        chk("t5_idle_ticks", n_ena, 15);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t5_run_again", running, 1);
        step();
        start = 1'b1; pause = 1'b1;
        step();
        start = 1'b0; pause = 1'b0;
        chk("t5_ps_loadN", loadN, 0);
        chk("t5_ps_running", running, 0);
        step();
        chk("t5_ps_run", running, 1);
        step();
        resetN = 1'b0;
        step();
        chk("t5_rst_loadN", loadN, 1);
        chk("t5_rst_running", running, 0);
        chk("t5_rst_expired", expired, 0);
        chk("t5_rst_time_up", time_up, 0);
        chk("t5_rst_ena", ena, 0);
        chk("t5_rst_digits", digits(), 12);
        resetN = 1'b1;
        step();
        chk("t5_post_rst_idle", running, 0);

        // Test 6: preset 00 expires after one RUN cycle with no ticks
        start_z = 1'b1;
        step();
        start_z = 1'b0;
        chk("t6_load_loadN", loadN_z, 0);
        step();
        chk("t6_run_running", running_z, 1);
        chk("t6_run_ena", ena_z, 0);
        chk("t6_run_time_up", time_up_z, 0);
        step();
        chk("t6_exp_expired", expired_z, 1);
        chk("t6_exp_time_up", time_up_z, 1);
        chk("t6_exp_running", running_z, 0);
        step();
        chk("t6_time_up_pulse", time_up_z, 0);
        chk("t6_ticks", n_ena_z, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
